// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry, SRAM widths, control states and the
// pixel-address helper shared by the arbiter and its request FIFO.
package fb_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int AW       = 19;
    localparam int PW       = 18;
    localparam int REQ_W    = 10 + 9 + PW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // y*640 + x as two shifts and adds, kept at full 19-bit width
    function automatic logic [AW-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        return {1'b0, y, 9'b0} + {3'b0, y, 7'b0} + {9'b0, x};
    endfunction
endpackage

// File: rtl/fb_req_fifo.sv
// fb_req_fifo: small write-request FIFO; the caller only pushes when not full
// and only pops when not empty.
module fb_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = fb_pkg::REQ_W,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk50,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout,
    output logic [PTR_W:0] count
);
    import fb_pkg::*;

    logic [W-1:0]   mem_q [DEPTH];
    logic [W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PTR_W:0]   count_q, count_d;

    // pointers wrap on their own because DEPTH is a power of two
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        count_d = (push && !pop) ? count_q + 1'b1 :
                  (pop && !push) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign count = count_q;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port SRAM between the VGA pixel fetch (every
// phase-1 active cycle), buffered pixel writes and a full-frame clear.
module fb_arbiter #(
    parameter int H_ACTIVE   = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = fb_pkg::V_ACTIVE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk50,
    input  logic        rst_n,
    output logic        pix_en,
    input  logic        disp_den,
    input  logic [9:0]  disp_x,
    input  logic [8:0]  disp_y,
    output logic [5:0]  red,
    output logic [5:0]  green,
    output logic [5:0]  blue,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_x,
    input  logic [8:0]  wr_y,
    input  logic [17:0] wr_rgb,
    output logic        wr_drop,
    input  logic        clr_req,
    input  logic [17:0] clr_rgb,
    output logic        clr_busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [17:0] mem_wdata,
    input  logic [17:0] mem_rdata
);
    localparam int          CW   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam logic [18:0] LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    fb_pkg::state_t state_q, state_d;
    logic          phase_q, phase_d, alive_q, alive_d, vld_q, vld_d, blk_q, blk_d;
    logic [17:0]   rgb_q, rgb_d, clr_rgb_q, clr_rgb_d;
    logic [18:0]   clr_cnt_q, clr_cnt_d;
    logic [36:0]   head;
    logic [CW-1:0] count;
    logic          wslot, push, pop, in_range;

    fb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk50 (clk50),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({wr_x, wr_y, wr_rgb}),
        .dout  (head),
        .count (count)
    );

    // alive_q keeps wr_ready low while reset is held and for the release cycle
    assign wslot    = ~phase_q | ~disp_den;
    assign wr_ready = alive_q & (count < CW'(FIFO_DEPTH)) & (state_q == fb_pkg::ST_IDLE);
    assign push     = wr_valid & wr_ready;
    assign pop      = wslot & (state_q != fb_pkg::ST_CLEAR) & (count != '0);
    assign in_range = (head[36:27] < 10'(H_ACTIVE)) & (head[26:18] < 9'(V_ACTIVE));
    assign pix_en   = phase_q;
    assign clr_busy = state_q != fb_pkg::ST_IDLE;
    assign {red, green, blue} = rgb_q;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state_q <= fb_pkg::ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            fb_pkg::ST_IDLE:  if (clr_req) state_d = fb_pkg::ST_DRAIN;
            fb_pkg::ST_DRAIN: if (count == '0) state_d = fb_pkg::ST_CLEAR;
            fb_pkg::ST_CLEAR: if (wslot && clr_cnt_q == LAST) state_d = fb_pkg::ST_IDLE;
            default:          state_d = fb_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d   = ~phase_q;
        alive_d   = 1'b1;
        vld_d     = phase_q & disp_den;
        blk_d     = phase_q & ~disp_den;
        rgb_d     = vld_q ? mem_rdata : blk_q ? '0 : rgb_q;
        clr_rgb_d = (state_q == fb_pkg::ST_IDLE && clr_req) ? clr_rgb : clr_rgb_q;
        clr_cnt_d = (state_q == fb_pkg::ST_CLEAR && wslot) ?
                    ((clr_cnt_q == LAST) ? '0 : clr_cnt_q + 1'b1) : clr_cnt_q;
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            alive_q   <= 1'b0;
            vld_q     <= 1'b0;
            blk_q     <= 1'b0;
            rgb_q     <= '0;
            clr_rgb_q <= '0;
            clr_cnt_q <= '0;
        end else begin
            phase_q   <= phase_d;
            alive_q   <= alive_d;
            vld_q     <= vld_d;
            blk_q     <= blk_d;
            rgb_q     <= rgb_d;
            clr_rgb_q <= clr_rgb_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // out-of-range entries still consume their pop but leave the slot idle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_drop   = 1'b0;
        if (!wslot) begin
            mem_en   = 1'b1;
            mem_addr = fb_pkg::pix_addr(disp_x, disp_y);
        end else if (state_q == fb_pkg::ST_CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = clr_rgb_q;
        end else if (pop) begin
            mem_en    = in_range;
            mem_we    = in_range;
            mem_addr  = in_range ? fb_pkg::pix_addr(head[36:27], head[26:18]) : '0;
            mem_wdata = in_range ? head[17:0] : '0;
            wr_drop   = ~in_range;
        end
    end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, write-request FIFO entries (power of two).
REQ-004 SHALL have port clk50  in  1  50 MHz clock, sole clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_en  out  1  pixel strobe to VGA timing generator enable input.
REQ-007 SHALL have ports disp_den/disp_x/disp_y  in  1/10/9  display enable and coordinate of pixel to fetch.
REQ-008 SHALL have ports red/green/blue  out  6 each  fetched pixel colour to timing generator.
REQ-009 SHALL have ports wr_valid/wr_ready  in/out  1/1  writer handshake.
REQ-010 SHALL have ports wr_x/wr_y/wr_rgb  in  10/9/18  write coordinate and colour {r,g,b}.
REQ-011 SHALL have port wr_drop  out  1  one-cycle pulse on dropped out-of-range write.
REQ-012 SHALL have ports clr_req/clr_rgb/clr_busy  in/in/out  1/18/1  frame-clear request, fill colour, busy.
REQ-013 SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  out  1/1/19/18  single-port SRAM command.
REQ-014 SHALL have port mem_rdata  in  18  SRAM read data, valid exactly one cycle after read command.

Function
REQ-015 SHALL toggle a phase register every clk50; pix_en = 1 when phase = 1 (25 MHz pixel rate).
REQ-016 Phase-1 cycle with disp_den=1 SHALL be a display slot: mem_en=1, mem_we=0, mem_addr = disp_y*640 + disp_x (shift-add, 19-bit, no truncation).
REQ-017 Read data SHALL be registered into red/green/blue on the cycle after the display slot (bits 17:12, 11:6, 5:0); latency command-to-output = 1 cycle, held until next update.
REQ-018 Phase-1 cycle with disp_den=0 SHALL load red/green/blue with 0 on the next cycle and SHALL be a write slot.
REQ-019 Every phase-0 cycle SHALL be a write slot; display never loses a slot.
REQ-020 In a write slot the block SHALL pop the FIFO head (IDLE/DRAIN) or issue the next clear word (CLEAR); mem_en=mem_we=1; otherwise mem_en=0.
REQ-021 FIFO push SHALL occur when wr_valid & wr_ready; wr_ready = (count < FIFO_DEPTH) & state==IDLE, from registered state only; push and pop in same cycle SHALL leave count unchanged.
REQ-022 Entries with wr_x >= H_ACTIVE or wr_y >= V_ACTIVE SHALL be accepted, not written, and SHALL pulse wr_drop the cycle they are popped; the slot is unused.
REQ-023 Control FSM states IDLE, DRAIN, CLEAR: IDLE -> DRAIN on clr_req=1; DRAIN -> CLEAR when FIFO empty; CLEAR -> IDLE after writing address H_ACTIVE*V_ACTIVE-1.
REQ-024 clr_rgb SHALL be captured on the IDLE->DRAIN transition; clr_req in DRAIN/CLEAR SHALL be ignored.
REQ-025 CLEAR SHALL write addresses 0..307199 in ascending order, one per write slot.
REQ-026 clr_busy SHALL be 1 in DRAIN and CLEAR, 0 in IDLE (registered).
REQ-027 FIFO write/read pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 While rst_n=0: phase=0, pix_en=0, red/green/blue=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, wr_ready=0, wr_drop=0, clr_busy=0, FIFO empty, state IDLE, clear counter 0.
REQ-029 Reset asserted mid-CLEAR or with FIFO occupied SHALL discard all pending work; no write issued after reset assertion.

Structure
REQ-030 H_ACTIVE, V_ACTIVE, address width 19, pixel width 18 and FSM state encoding SHALL reside in shared package fb_pkg.
REQ-031 The write-request FIFO SHALL be one sub-module, fb_req_fifo (width 37, depth FIFO_DEPTH).

Verification
REQ-032 Reset release, disp_den=1, x=5,y=2 at phase 1 -> mem_addr=1285 read; rdata 0x3F000 -> red=0x3F, green=0, blue=0 one cycle later.
REQ-033 Push 5 writes back-to-back, no pops possible (hold phase checks) -> wr_ready=0 after 4 accepted; 5th held until a pop.
REQ-034 Write x=639,y=479,rgb=0x15555 -> mem_we at addr 307199 in next write slot; write x=640 -> wr_drop pulse, no mem_we.
REQ-035 clr_req with 2 FIFO entries -> wr_ready=0, both entries written, then 307200 writes of clr_rgb ascending, clr_busy falls after last.
REQ-036 rst_n low at clear word 1000 -> all outputs reset values next edge, no further mem_we, state IDLE after release.
